cacheline_adaptor: RTL and testbench

Converts the cache's single-cycle 256-bit line transfers into the 4-beat, 64-bit burst protocol of the burst memory model (`ParamMemory`, 4 × 64-bit bursts). It sits between the last-level cache and the testbench memory, directly upstream of the memory port. It aligns addresses, serialises writebacks, assembles fills, and returns one line-level response per transaction.

---
 rtl/cacheline_adaptor_if.sv | 48 ++++
 rtl/cacheline_adaptor.sv | 186 ++++++++++++++++++
 tb/tb_cacheline_adaptor.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_if.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor_if
//
// Bundles the two buses around the cache-line adaptor:
//   cache side  : line_i / line_o (whole lines), address_i, read_i, write_i,
//                 resp_o (one-cycle completion pulse)
//   memory side : burst_i / burst_o (one beat), address_o, read_o, write_o,
//                 resp_i (one beat moves per cycle it is high)
//
// Modports:
//   slave  - the adaptor itself (consumes requests and read beats, produces
//            fills, write beats and burst requests)
//   master - the surroundings (the cache and the burst memory together)
//
// The clock and reset are deliberately not part of the bundle.
// ---------------------------------------------------------------------------
interface cacheline_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
);

    // cache side
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [31:0]            address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;

    // memory side
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [31:0]            address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor
//
// Turns single-cycle whole-line transfers from the last-level cache into
// BEATS-long bursts of BURST_WIDTH bits towards the burst memory model.
// Writebacks are latched and serialised beat 0 first (bits [63:0] first);
// fills are assembled slot by slot as beats arrive. Each line transaction
// ends with a one-cycle resp_o pulse.
//
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - cacheline_adaptor_if.slave
//           line_i/address_i/read_i/write_i : cache request (level-sensitive)
//           line_o/resp_o                   : fill line and completion pulse
//           burst_i/resp_i                  : memory read beat and handshake
//           burst_o/address_o/read_o/write_o: burst to memory
//
// All outputs are functions of registered state only.
// ---------------------------------------------------------------------------
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus
);

    localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg,   cnt_next;
    logic [LINE_WIDTH-1:0]   buffer_reg, buffer_next;
    logic [31:0]             addr_reg,  addr_next;

    logic                    accept_write;
    logic                    fill_beat;
    logic [31:0]             aligned_addr;
    logic [BEATS-1:0]        slot_hit;
    logic [BURST_WIDTH-1:0]  beat_out [BEATS];
    logic [BURST_WIDTH-1:0]  burst_mux;

    // Byte-offset bits of the request address are dropped on purpose.
    logic                    unused_offset;
    assign unused_offset = ^bus.address_i[OFFSET_W-1:0];

    assign aligned_addr = {bus.address_i[31:OFFSET_W], OFFSET_W'(0)};

    // -----------------------------------------------------------------------
    // State and beat counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Requests are only looked at in IDLE and the memory
    // handshake only in READ/WRITE, so stray activity elsewhere is inert.
    // The counter wraps from the last beat back to 0 on its own.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        accept_write = 1'b0;
        fill_beat    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Write wins when both requests are up: a dirty victim has
                // to leave before its replacement can be fetched.
                if (bus.write_i) begin
                    accept_write = 1'b1;
                    addr_next    = aligned_addr;
                    cnt_next     = '0;
                    state_next   = WRITE;
                end else if (bus.read_i) begin
                    addr_next    = aligned_addr;
                    cnt_next     = '0;
                    state_next   = READ;
                end
            end

            READ: begin
                if (bus.resp_i) begin
                    fill_beat = 1'b1;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end

            WRITE: begin
                if (bus.resp_i) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Per-beat slot logic. Slot gi holds bits [gi*BURST_WIDTH +: BURST_WIDTH]
    // of the line: it is loaded whole on write acceptance, or from burst_i
    // when a read beat lands while the counter points at it. The same slot
    // select drives the write-beat mux, gated so burst_o is 0 outside WRITE.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);

            assign slot_hit[gi] = (cnt_reg == SLOT);

            assign buffer_next[gi*BURST_WIDTH +: BURST_WIDTH] =
                accept_write               ? bus.line_i[gi*BURST_WIDTH +: BURST_WIDTH] :
                (fill_beat && slot_hit[gi]) ? bus.burst_i :
                                             buffer_reg[gi*BURST_WIDTH +: BURST_WIDTH];

            assign beat_out[gi] = ((state_reg == WRITE) && slot_hit[gi]) ?
                                  buffer_reg[gi*BURST_WIDTH +: BURST_WIDTH] :
                                  '0;
        end
    endgenerate

    // At most one slot is selected, so an OR tree is the mux.
    always_comb begin
        burst_mux = '0;
        for (int i = 0; i < BEATS; i++) begin
            burst_mux = burst_mux | beat_out[i];
        end
    end

    // -----------------------------------------------------------------------
    // Line buffer and address register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_reg <= '0;
            addr_reg   <= '0;
        end else begin
            buffer_reg <= buffer_next;
            addr_reg   <= addr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // -----------------------------------------------------------------------
    assign bus.read_o    = (state_reg == READ);
    assign bus.write_o   = (state_reg == WRITE);
    assign bus.resp_o    = (state_reg == DONE);
    assign bus.burst_o   = burst_mux;
    assign bus.address_o = addr_reg;
    assign bus.line_o    = buffer_reg;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Bench for cacheline_adaptor. Inputs change on the falling clock edge and
// outputs are sampled there too, away from the rising edge. Expected lines,
// addresses and write beats are queued when stimulus is driven and popped
// when the adaptor produces the matching output.
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cacheline_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus ();

    cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [LW-1:0] line_q [$];
    logic [31:0]   addr_q [$];
    logic [BW-1:0] beat_q [$];
    logic [BW-1:0] obs_q  [$];
    logic [LW-1:0] last_fill;

    task automatic step();
        @(negedge clk);
    endtask

    // Memory model for fills: beat k is offered on the k-th set bit of pat.
    task automatic run_fill(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                            input logic [BW-1:0] b2, input logic [BW-1:0] b3,
                            input logic [15:0] pat, input int plen,
                            output int read_hi, output int resp_seen);
        logic [BW-1:0] bs [4];
        int k;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        k = 0; read_hi = 0; resp_seen = 0;
        for (int c = 0; c < plen; c++) begin
            if (bus.read_o === 1'b1) read_hi++;
            if (bus.resp_o === 1'b1) resp_seen++;
            if (pat[c] && k < 4) begin
                bus.resp_i  = 1'b1;
                bus.burst_i = bs[k];
                k++;
            end else begin
                bus.resp_i  = 1'b0;
                bus.burst_i = {$urandom, $urandom};
            end
            step();
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
    endtask

    // Memory model for writebacks: records burst_o on every accepted beat.
    task automatic run_drain(input logic [15:0] pat, input int plen,
                             output int write_hi, output int resp_seen);
        write_hi = 0; resp_seen = 0;
        for (int c = 0; c < plen; c++) begin
            if (bus.write_o === 1'b1) write_hi++;
            if (bus.resp_o === 1'b1) resp_seen++;
            if (pat[c]) begin
                obs_q.push_back(bus.burst_o);
                bus.resp_i = 1'b1;
            end else begin
                bus.resp_i = 1'b0;
            end
            step();
        end
        bus.resp_i = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (bus.read_o !== 1'b0) begin n_bad++; $display("FAIL rst_read_o: got %b want 0", bus.read_o); end
        n_cmp++; if (bus.write_o !== 1'b0) begin n_bad++; $display("FAIL rst_write_o: got %b want 0", bus.write_o); end
        n_cmp++; if (bus.resp_o !== 1'b0) begin n_bad++; $display("FAIL rst_resp_o: got %b want 0", bus.resp_o); end
        n_cmp++; if (bus.burst_o !== '0) begin n_bad++; $display("FAIL rst_burst_o: got %h want 0", bus.burst_o); end
        n_cmp++; if (bus.line_o !== '0) begin n_bad++; $display("FAIL rst_line_o: got %h want 0", bus.line_o); end
        n_cmp++; if (bus.address_o !== 32'h0) begin n_bad++; $display("FAIL rst_address_o: got %h want 0", bus.address_o); end
        rst = 1'b0;
        step();
        $display("reset: outputs checked");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_read();
        logic [BW-1:0] b0, b1, b2, b3;
        logic [LW-1:0] exp_l;
        logic [31:0]   exp_a;
        int rh, rs;
        b0 = 64'h1111_1111_1111_1111; b1 = 64'h2222_2222_2222_2222;
        b2 = 64'h3333_3333_3333_3333; b3 = 64'h4444_4444_4444_4444;
        bus.address_i = 32'h0000_1234;
        bus.read_i    = 1'b1;
        addr_q.push_back(32'h0000_1220);
        line_q.push_back({b3, b2, b1, b0});
        step();
        exp_a = addr_q.pop_front();
        n_cmp++; if (bus.address_o !== exp_a) begin n_bad++; $display("FAIL rd_addr: got %h want %h", bus.address_o, exp_a); end
        n_cmp++; if (bus.write_o !== 1'b0) begin n_bad++; $display("FAIL rd_write_o: got %b want 0", bus.write_o); end
        run_fill(b0, b1, b2, b3, 16'h000F, 4, rh, rs);
        bus.read_i = 1'b0;
        exp_l = line_q.pop_front();
        n_cmp++; if (rh !== 4) begin n_bad++; $display("FAIL rd_read_o_span: got %0d cycles high want 4", rh); end
        n_cmp++; if (rs !== 0) begin n_bad++; $display("FAIL rd_early_resp: got %0d pulses want 0", rs); end
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL rd_resp_o: got %b want 1", bus.resp_o); end
        n_cmp++; if (bus.read_o !== 1'b0) begin n_bad++; $display("FAIL rd_read_drop: got %b want 0", bus.read_o); end
        n_cmp++; if (bus.line_o !== exp_l) begin n_bad++; $display("FAIL rd_line: got %h want %h", bus.line_o, exp_l); end
        last_fill = exp_l;
        step();
        n_cmp++; if (bus.resp_o !== 1'b0) begin n_bad++; $display("FAIL rd_resp_pulse: got %b want 0", bus.resp_o); end
        n_cmp++; if (bus.line_o !== last_fill) begin n_bad++; $display("FAIL rd_line_hold: got %h want %h", bus.line_o, last_fill); end
        $display("read  addr=%h line=%h", exp_a, exp_l);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_write();
        logic [BW-1:0] d0, d1, d2, d3, exp_b, got_b;
        logic [31:0]   exp_a;
        int wh, rs;
        d0 = 64'h0123_4567_89AB_CDEF; d1 = 64'hFEDC_BA98_7654_3210;
        d2 = 64'hA5A5_5A5A_0F0F_F0F0; d3 = 64'h0000_FFFF_1234_8765;
        bus.line_i    = {d3, d2, d1, d0};
        bus.address_i = 32'h8000_00FF;
        bus.write_i   = 1'b1;
        beat_q.push_back(d0); beat_q.push_back(d1);
        beat_q.push_back(d2); beat_q.push_back(d3);
        addr_q.push_back(32'h8000_00E0);
        step();
        bus.write_i = 1'b0;
        bus.line_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        exp_a = addr_q.pop_front();
        n_cmp++; if (bus.write_o !== 1'b1) begin n_bad++; $display("FAIL wr_write_o: got %b want 1", bus.write_o); end
        n_cmp++; if (bus.read_o !== 1'b0) begin n_bad++; $display("FAIL wr_read_o: got %b want 0", bus.read_o); end
        n_cmp++; if (bus.address_o !== exp_a) begin n_bad++; $display("FAIL wr_addr: got %h want %h", bus.address_o, exp_a); end
        // beats on cycles 0,1,3,4 with a gap at cycle 2
        run_drain(16'b11011, 5, wh, rs);
        n_cmp++; if (wh !== 5) begin n_bad++; $display("FAIL wr_write_o_span: got %0d cycles high want 5", wh); end
        n_cmp++; if (rs !== 0) begin n_bad++; $display("FAIL wr_early_resp: got %0d pulses want 0", rs); end
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL wr_resp_o: got %b want 1", bus.resp_o); end
        n_cmp++; if (bus.write_o !== 1'b0) begin n_bad++; $display("FAIL wr_write_drop: got %b want 0", bus.write_o); end
        n_cmp++; if (bus.burst_o !== '0) begin n_bad++; $display("FAIL wr_burst_idle: got %h want 0", bus.burst_o); end
        n_cmp++; if (bus.line_o !== {d3, d2, d1, d0}) begin n_bad++; $display("FAIL wr_line_buf: got %h want %h", bus.line_o, {d3, d2, d1, d0}); end
        n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL wr_beat_count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (beat_q.size() > 0 && obs_q.size() > 0) begin
                exp_b = beat_q.pop_front();
                got_b = obs_q.pop_front();
                n_cmp++; if (got_b !== exp_b) begin n_bad++; $display("FAIL wr_beat%0d: got %h want %h", i, got_b, exp_b); end
            end
        end
        beat_q.delete(); obs_q.delete();
        step();
        n_cmp++; if (bus.resp_o !== 1'b0) begin n_bad++; $display("FAIL wr_resp_pulse: got %b want 0", bus.resp_o); end
        $display("write addr=%h line=%h", exp_a, {d3, d2, d1, d0});
    endtask

    // -----------------------------------------------------------------------
    task automatic test_gapped_read();
        logic [BW-1:0] b0, b1, b2, b3;
        logic [LW-1:0] exp_l;
        logic [31:0]   exp_a;
        int rh, rs;
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
        bus.address_i = 32'h0000_ABCD;
        bus.read_i    = 1'b1;
        addr_q.push_back(32'h0000_ABC0);
        line_q.push_back({b3, b2, b1, b0});
        step();
        // resp_i = 1,0,0,1,1,0,1
        run_fill(b0, b1, b2, b3, 16'b1011001, 7, rh, rs);
        bus.read_i = 1'b0;
        exp_a = addr_q.pop_front();
        exp_l = line_q.pop_front();
        n_cmp++; if (rh !== 7) begin n_bad++; $display("FAIL gap_read_o_span: got %0d cycles high want 7", rh); end
        n_cmp++; if (rs !== 0) begin n_bad++; $display("FAIL gap_early_resp: got %0d pulses want 0", rs); end
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL gap_resp_o: got %b want 1", bus.resp_o); end
        n_cmp++; if (bus.address_o !== exp_a) begin n_bad++; $display("FAIL gap_addr: got %h want %h", bus.address_o, exp_a); end
        n_cmp++; if (bus.line_o !== exp_l) begin n_bad++; $display("FAIL gap_line: got %h want %h", bus.line_o, exp_l); end
        last_fill = exp_l;
        step();
        $display("read  addr=%h line=%h (gapped)", exp_a, exp_l);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_simultaneous();
        logic [BW-1:0] d0, d1, d2, d3, b0, b1, b2, b3, exp_b, got_b;
        logic [LW-1:0] exp_l;
        int wh, rh, rs;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom}; d3 = {$urandom, $urandom};
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
        bus.line_i    = {d3, d2, d1, d0};
        bus.address_i = 32'h0000_0040;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        beat_q.push_back(d0); beat_q.push_back(d1);
        beat_q.push_back(d2); beat_q.push_back(d3);
        step();
        bus.write_i = 1'b0;
        n_cmp++; if (bus.write_o !== 1'b1) begin n_bad++; $display("FAIL sim_write_o: got %b want 1", bus.write_o); end
        n_cmp++; if (bus.read_o !== 1'b0) begin n_bad++; $display("FAIL sim_read_o: got %b want 0", bus.read_o); end
        run_drain(16'h000F, 4, wh, rs);
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL sim_wr_resp: got %b want 1", bus.resp_o); end
        for (int i = 0; i < 4; i++) begin
            if (beat_q.size() > 0 && obs_q.size() > 0) begin
                exp_b = beat_q.pop_front();
                got_b = obs_q.pop_front();
                n_cmp++; if (got_b !== exp_b) begin n_bad++; $display("FAIL sim_beat%0d: got %h want %h", i, got_b, exp_b); end
            end
        end
        beat_q.delete(); obs_q.delete();
        $display("write addr=%h line=%h (read+write)", 32'h0000_0040, {d3, d2, d1, d0});
        // read_i is still high: one IDLE cycle, then the read is accepted
        step();
        n_cmp++; if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000) begin n_bad++; $display("FAIL sim_idle_gap: got r/w/resp=%b want 000", {bus.read_o, bus.write_o, bus.resp_o}); end
        line_q.push_back({b3, b2, b1, b0});
        step();
        n_cmp++; if (bus.read_o !== 1'b1) begin n_bad++; $display("FAIL sim_read_accept: got %b want 1", bus.read_o); end
        run_fill(b0, b1, b2, b3, 16'h000F, 4, rh, rs);
        bus.read_i = 1'b0;
        exp_l = line_q.pop_front();
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL sim_rd_resp: got %b want 1", bus.resp_o); end
        n_cmp++; if (bus.line_o !== exp_l) begin n_bad++; $display("FAIL sim_rd_line: got %h want %h", bus.line_o, exp_l); end
        last_fill = exp_l;
        step();
        $display("read  addr=%h line=%h (after write)", 32'h0000_0040, exp_l);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [BW-1:0] b0, b1, b2, b3;
        logic [LW-1:0] exp_l;
        logic [31:0]   exp_a;
        int rh, rs, resp_cnt;
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
        bus.address_i = 32'h0000_2000;
        bus.read_i    = 1'b1;
        step();
        run_fill(b0, b1, b2, b3, 16'h0003, 2, rh, rs);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.read_o !== 1'b0) begin n_bad++; $display("FAIL rmid_read_o: got %b want 0", bus.read_o); end
        n_cmp++; if (bus.line_o !== '0) begin n_bad++; $display("FAIL rmid_line_o: got %h want 0", bus.line_o); end
        n_cmp++; if (bus.address_o !== 32'h0) begin n_bad++; $display("FAIL rmid_address_o: got %h want 0", bus.address_o); end
        n_cmp++; if (bus.resp_o !== 1'b0) begin n_bad++; $display("FAIL rmid_resp_o: got %b want 0", bus.resp_o); end
        bus.read_i = 1'b0;
        resp_cnt = 0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (bus.resp_o === 1'b1) resp_cnt++;
            step();
        end
        n_cmp++; if (resp_cnt !== 0) begin n_bad++; $display("FAIL rmid_no_resp: got %0d pulses want 0", resp_cnt); end
        $display("read  addr=%h aborted by reset", 32'h0000_2000);
        // fresh read after release
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
        bus.address_i = 32'h0000_3004;
        bus.read_i    = 1'b1;
        addr_q.push_back(32'h0000_3000);
        line_q.push_back({b3, b2, b1, b0});
        step();
        run_fill(b0, b1, b2, b3, 16'h000F, 4, rh, rs);
        bus.read_i = 1'b0;
        exp_a = addr_q.pop_front();
        exp_l = line_q.pop_front();
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL rmid_new_resp: got %b want 1", bus.resp_o); end
        n_cmp++; if (bus.address_o !== exp_a) begin n_bad++; $display("FAIL rmid_new_addr: got %h want %h", bus.address_o, exp_a); end
        n_cmp++; if (bus.line_o !== exp_l) begin n_bad++; $display("FAIL rmid_new_line: got %h want %h", bus.line_o, exp_l); end
        last_fill = exp_l;
        step();
        $display("read  addr=%h line=%h (after reset)", exp_a, exp_l);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stray_resp();
        logic [BW-1:0] b0, b1, b2, b3;
        logic [LW-1:0] exp_l;
        int rh, rs, busy;
        busy = 0;
        for (int c = 0; c < 3; c++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            step();
            if (bus.resp_o === 1'b1 || bus.read_o === 1'b1 || bus.write_o === 1'b1) busy++;
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL stray_activity: got %0d busy cycles want 0", busy); end
        n_cmp++; if (bus.line_o !== last_fill) begin n_bad++; $display("FAIL stray_line_hold: got %h want %h", bus.line_o, last_fill); end
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
        bus.address_i = 32'h0000_0080;
        bus.read_i    = 1'b1;
        line_q.push_back({b3, b2, b1, b0});
        step();
        run_fill(b0, b1, b2, b3, 16'h000F, 4, rh, rs);
        bus.read_i = 1'b0;
        exp_l = line_q.pop_front();
        n_cmp++; if (bus.resp_o !== 1'b1) begin n_bad++; $display("FAIL stray_next_resp: got %b want 1", bus.resp_o); end
        n_cmp++; if (bus.line_o !== exp_l) begin n_bad++; $display("FAIL stray_next_line: got %h want %h", bus.line_o, exp_l); end
        step();
        $display("read  addr=%h line=%h (after stray resp_i)", 32'h0000_0080, exp_l);
    endtask

    // -----------------------------------------------------------------------
    initial begin
        rst           = 1'b1;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        last_fill     = '0;

        test_reset();
        test_read();
        test_write();
        test_gapped_read();
        test_simultaneous();
        test_reset_mid();
        test_stray_resp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
